// File: rtl/fp_pkg.sv
// Shared FP arithmetic definitions: operand/result type codes, constants,
// sequencer state encoding and operand classification.
package fp_pkg;

  typedef enum logic [1:0] {
    T_NUM,
    T_NAN,
    T_ZER,
    T_INF
  } fp_type_t;

  localparam int          BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FFF_FFFF;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASS,
    ST_DIV,
    ST_NORM,
    ST_ROUND,
    ST_RANGE,
    ST_FINISH
  } state_t;

  // Subnormals are flushed to zero.
  function automatic fp_type_t classify(input logic [7:0] ex, input logic [22:0] frac);
    if (ex == 8'hFF) return (frac == 23'd0) ? T_INF : T_NAN;
    if (ex == 8'h00) return T_ZER;
    return T_NUM;
  endfunction

endpackage

// File: rtl/fp_mant_divider.sv
// 26-step restoring divider for two 24-bit mantissas; produces q = floor(m1*2^25/m2).
module fp_mant_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] m1,
  input  logic [23:0] m2,
  output logic        busy,
  output logic [25:0] q
);

  logic [24:0] r;
  logic [23:0] d;
  logic [4:0]  cnt;
  logic        active;
  logic [24:0] diff;
  logic        ge;

  assign diff = r - {1'b0, d};
  assign ge   = (r >= {1'b0, d});
  // busy drops during the final step so the caller can leave on that same edge.
  assign busy = active && (cnt != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r      <= '0;
      d      <= '0;
      cnt    <= '0;
      active <= 1'b0;
      q      <= '0;
    end else if (start) begin
      r      <= {1'b0, m1};
      d      <= m2;
      cnt    <= 5'd25;
      active <= 1'b1;
      q      <= '0;
    end else if (active) begin
      q[cnt] <= ge;
      // Remainder stays below 2*d, so the shifted value always fits 25 bits.
      r      <= ge ? {diff[23:0], 1'b0} : {r[23:0], 1'b0};
      if (cnt == 5'd0) active <= 1'b0;
      else             cnt    <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/float_divider.sv
// Sequential IEEE754 single-precision divider, res = op1 / op2, ready/done handshake:
// ready is a start request sampled only when idle; done pulses one cycle as res updates.
module float_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] res,
  output logic        done
);

  state_t             state;
  logic               s1, s2;
  logic [7:0]         e1r, e2r;
  logic [23:0]        m1r, m2r;
  fp_type_t           rtype;
  logic signed [9:0]  e;
  logic [23:0]        sig;
  logic               guard;

  fp_type_t           t1, t2, rt_next;
  logic               div_start;
  logic               div_busy;
  logic [25:0]        q;
  logic [24:0]        sig_inc;
  logic [30:0]        body;

  always_comb begin
    t1 = classify(e1r, m1r[22:0]);
    t2 = classify(e2r, m2r[22:0]);
    rt_next = T_NUM;
    if (t1 == T_NAN || t2 == T_NAN || (t1 == T_ZER && t2 == T_ZER) ||
        (t1 == T_INF && t2 == T_INF))
      rt_next = T_NAN;
    else if (t1 == T_INF || t2 == T_ZER)
      rt_next = T_INF;
    else if (t1 == T_ZER || t2 == T_INF)
      rt_next = T_ZER;
  end

  assign div_start = (state == ST_CLASS) && (rt_next == T_NUM);
  assign sig_inc   = {1'b0, sig} + {24'd0, guard};

  always_comb begin
    case (rtype)
      T_ZER:   body = 31'd0;
      T_INF:   body = INF[30:0];
      T_NAN:   body = QNAN[30:0];
      default: body = {e[7:0], sig[22:0]};
    endcase
  end

  fp_mant_divider u_mant (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .m1    (m1r),
    .m2    (m2r),
    .busy  (div_busy),
    .q     (q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      s1    <= 1'b0;
      s2    <= 1'b0;
      e1r   <= '0;
      e2r   <= '0;
      m1r   <= '0;
      m2r   <= '0;
      rtype <= T_NUM;
      e     <= '0;
      sig   <= '0;
      guard <= 1'b0;
      res   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ready) begin
            s1    <= op1[31];
            s2    <= op2[31];
            e1r   <= op1[30:23];
            e2r   <= op2[30:23];
            m1r   <= {1'b1, op1[22:0]};
            m2r   <= {1'b1, op2[22:0]};
            state <= ST_CLASS;
          end
        end
        ST_CLASS: begin
          rtype <= rt_next;
          // Biased exponent spans -126..380, held as 10-bit signed.
          e     <= $signed({2'b00, e1r}) - $signed({2'b00, e2r}) + $signed(10'(BIAS));
          state <= (rt_next == T_NUM) ? ST_DIV : ST_FINISH;
        end
        ST_DIV: begin
          if (!div_busy) state <= ST_NORM;
        end
        ST_NORM: begin
          if (q[25]) begin
            sig   <= q[25:2];
            guard <= q[1];
          end else begin
            sig   <= q[24:1];
            guard <= q[0];
            e     <= e - 10'sd1;
          end
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (sig_inc[24]) begin
            sig <= 24'h80_0000;
            e   <= e + 10'sd1;
          end else begin
            sig <= sig_inc[23:0];
          end
          state <= ST_RANGE;
        end
        ST_RANGE: begin
          if (e <= 10'sd0)        rtype <= T_ZER;
          else if (e >= 10'sd255) rtype <= T_INF;
          state <= ST_FINISH;
        end
        ST_FINISH: begin
          res   <= {s1 ^ s2, body};
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider: directed spec cases, abort/recovery,
// back-to-back starts and randomized operands against an arithmetic reference model.
module tb_float_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] op1, op2;
  logic [31:0] res;
  logic        done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  float_divider dut (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .op1   (op1),
    .op2   (op2),
    .res   (res),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // 0 number, 1 NaN, 2 zero, 3 infinity
  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 3 : 1;
    if (x[30:23] == 8'h00) return 2;
    return 0;
  endfunction

  // Returns {special, result}; quotient from plain integer division of the mantissas.
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int     ta, tb, e;
    logic   s;
    longint q, sig;
    s  = a[31] ^ b[31];
    ta = cls(a);
    tb = cls(b);
    if (ta == 1 || tb == 1 || (ta == 2 && tb == 2) || (ta == 3 && tb == 3))
      return {1'b1, s, 31'h7FFF_FFFF};
    if (ta == 3 || tb == 2) return {1'b1, s, 31'h7F80_0000};
    if (ta == 2 || tb == 3) return {1'b1, s, 31'h0};
    q = (longint'({1'b1, a[22:0]}) << 25) / longint'({1'b1, b[22:0]});
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (64'sd1 << 25)) sig = (q >> 2) + ((q >> 1) & 1);
    else begin
      sig = (q >> 1) + (q & 1);
      e--;
    end
    if (sig == (64'sd1 << 24)) begin
      sig = 64'sd1 << 23;
      e++;
    end
    if (e <= 0)   return {1'b0, s, 31'h0};
    if (e >= 255) return {1'b0, s, 31'h7F80_0000};
    return {1'b0, s, 8'(e), sig[22:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    logic [31:0] x;
    int sel;
    x   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel == 0)      x[30:23] = 8'h00;
    else if (sel == 1) x[30:23] = 8'hFF;
    else if (sel == 2) begin
      x[30:23] = 8'hFF;
      x[22:0]  = 23'd0;
    end else           x[30:23] = 8'($urandom_range(90, 165));
    return x;
  endfunction

  // Counts edges after the start edge until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 100);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    @(negedge clk);
    op1   = a;
    op2   = b;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    wait_done(cyc);
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " res"}, res, exp_res);
    @(posedge clk);
    #1;
    check({tag, " done width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [32:0] r;
    int cyc, seen;

    rst   = 1'b1;
    ready = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset res", res, 32'h0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 31);
    run_op("1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 31);
    run_op("0/0", 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 2);
    run_op("-1/0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 2);
    run_op("inf/inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FFF_FFFF, 2);
    run_op("1/inf", 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 2);
    run_op("overflow", 32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 31);
    run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 31);

    // Back-to-back: ready held high across two numeric operations.
    @(negedge clk);
    op1   = 32'h40C0_0000;
    op2   = 32'h4000_0000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    op1 = 32'h3F80_0000;
    op2 = 32'h4040_0000;
    wait_done(cyc);
    check("b2b first latency", 32'(cyc), 32'd31);
    check("b2b first res", res, 32'h4040_0000);
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("b2b first done width", {31'd0, done}, 32'd0);
    wait_done(cyc);
    check("b2b second latency", 32'(cyc), 32'd31);
    check("b2b second res", res, 32'h3EAA_AAAB);
    @(posedge clk);
    #1;
    check("b2b second done width", {31'd0, done}, 32'd0);

    // Abort: reset pulsed at k+10 of a numeric operation.
    @(negedge clk);
    op1   = 32'h40C0_0000;
    op2   = 32'h4000_0000;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort res", res, 32'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort no done", 32'(seen), 32'd0);
    check("abort res held", res, 32'h0);
    run_op("-10/5", 32'hC120_0000, 32'h40A0_0000, 32'hC000_0000, 31);

    for (int i = 0; i < 40; i++) begin
      a = gen_op();
      b = gen_op();
      r = ref_div(a, b);
      run_op($sformatf("rand%0d %h/%h", i, a, b), a, b, r[31:0], r[32] ? 2 : 31);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/float_divider.md
# float_divider

Sequential IEEE754 single-precision divider (res = op1 / op2) using the same ready/done handshake as the team's single-precision multiplier. It classifies operands, resolves special cases in two cycles, and otherwise runs a 26-step restoring mantissa division followed by normalize, round and range stages. It sits beside the multiplier in the FP arithmetic block and presents an identical port set to the shared operand/result datapath.

## Interface
- Parameters: none. Constants live in the shared package.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ready  in  1  start request; sampled only in ST_IDLE.
- op1  in  32  dividend, IEEE754 single.
- op2  in  32  divisor, IEEE754 single.
- res  out  32  quotient; registered; holds its value until the next completion.
- done  out  1  one-cycle completion pulse.

## Operation
- States: ST_IDLE, ST_CLASS, ST_DIV, ST_NORM, ST_ROUND, ST_RANGE, ST_FINISH.
- ST_IDLE, ready=1 at an edge:
  - latch sign, exponent and {1,frac} of op1 and op2;
  - go to ST_CLASS.
- ST_CLASS, operand classification:
  - exp=255, frac=0 → INF; exp=255, frac≠0 → NAN;
  - exp=0 → ZER (subnormals flushed to zero);
  - otherwise NUM.
- ST_CLASS, result type, in priority order:
  - NAN if either operand is NAN, or 0/0, or INF/INF;
  - else INF if op1 is INF or op2 is ZER;
  - else ZER if op1 is ZER or op2 is INF;
  - else NUM.
- ST_CLASS, datapath setup:
  - 10-bit signed exponent e = e1 − e2 + 127;
  - remainder R = {0,m1} (25 b), divisor D = m2, counter = 25;
  - NUM → ST_DIV, otherwise → ST_FINISH.
- ST_DIV, one step per cycle, i = 25 down to 0:
  - if R ≥ D: q[i] = 1, R = R − D; else q[i] = 0;
  - then R = R << 1;
  - leave for ST_NORM after i = 0 (26 cycles).
- ST_NORM:
  - q[25]=1: sig = q[25:2], guard = q[1];
  - else: sig = q[24:1], guard = q[0], e = e − 1.
- ST_ROUND, round-half-up on guard only (no sticky, ties away from zero, matching the multiplier):
  - sig += guard;
  - carry-out to 2^24: sig = 2^23, e = e + 1.
- ST_RANGE:
  - e ≤ 0 (sign bit set, or zero) → ZER;
  - e ≥ 255 → INF;
  - else NUM.
- ST_FINISH, on the edge leaving it:
  - res[30:0] = ZER 0, INF 0x7F800000, NAN 0x7FFFFFFF, NUM {e[7:0], sig[22:0]};
  - res[31] = s1 ^ s2 for every result type, NaN included;
  - done = 1; go to ST_IDLE.
- Width rules:
  - e has range −126..380 and must not wrap in 10 bits;
  - R is 25 bits, so R−D never needs more than 25 bits.

## Timing
- Reset: state ST_IDLE, res = 0x00000000, done = 0; all internal registers cleared.
- Start: ready high at edge k. ready is ignored in every state except ST_IDLE. op1/op2 may change after edge k.
- Special result (NAN/INF/ZER from classification): res valid and done high from edge k+2 to k+3.
- Numeric result:
  - ST_DIV edges k+2..k+27;
  - ST_NORM at k+28, ST_ROUND at k+29, ST_RANGE at k+30;
  - res valid and done high from edge k+31 to k+32.
- done falls at the next edge, which is in ST_IDLE. If ready is high at that edge, the next operation starts (back-to-back, 32-cycle period for numeric results).
- Reset mid-operation aborts immediately: no done pulse, res returns to 0.

## Structure
- Package fp_pkg, shared with the multiplier:
  - T_NUM/T_NAN/T_ZER/T_INF type encoding;
  - BIAS = 127;
  - QNAN = 0x7FFFFFFF, INF = 0x7F800000 (sign-stripped);
  - state encoding.
- Sub-module fp_mant_divider holds R, D, q, the counter and the restoring step. Interface: start, m1, m2, busy, q[25:0]. The top FSM owns classification, exponent, rounding and output.

## Test plan
- 6.0/2.0, op1 0x40C00000, op2 0x40000000 → res 0x40400000, done at k+31.
- 1.0/3.0, op1 0x3F800000, op2 0x40400000 → res 0x3EAAAAAB (guard round-up), done at k+31.
- Special cases, each with done at k+2:
  - 0/0 → 0x7FFFFFFF;
  - 0xBF800000/0x00000000 → 0xFF800000;
  - 0x7F800000/0x7F800000 → 0x7FFFFFFF;
  - 0x3F800000/0x7F800000 → 0x00000000.
- Range limits, each with done at k+31:
  - 0x7F000000/0x3F000000 → 0x7F800000 (overflow);
  - 0x00800000/0x40000000 → 0x00000000 (underflow).
- Abort and recovery: rst pulsed at k+10 → done never rises, res = 0. Then 0xC1200000/0x40A00000 (−10/5) → 0xC0000000 at k'+31.
- Back-to-back: ready held high across two numeric ops → done pulses at k+31 and k+63, both results correct, and each done is exactly one cycle wide.
